// File: rtl/exec_sequencer.sv
// Execute sequencer: holds PC/IR, decodes opcodes into per-phase datapath strobes and E2.
// Optional PHASE_CHECK_EN adds a sticky PHASE_ERR output for illegal phase sequences.
module exec_sequencer #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  RESET_VEC = {ADDR_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FETCH,
    input  logic              EXEC1,
    input  logic              EXEC2,
    input  logic [15:0]       MEM_DATA,
    input  logic              FLAG_Z,
    input  logic              FLAG_C,
    output logic              E2,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       IR,
    output logic              ADDR_SEL,
    output logic              REG_WE,
    output logic              WB_SEL,
    output logic              MEM_WE,
    output logic [1:0]        ALU_OP,
    output logic [2:0]        RD,
    output logic [2:0]        RA,
    output logic [2:0]        RB,
`ifdef PHASE_CHECK_EN
    output logic              PHASE_ERR,
`endif
    output logic              HALTED,
    output logic              ILLEGAL
);

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [3:0] op_s;
    logic [3:0] op_m1_s;
    logic       err_s;
    logic       live_s;
    logic       fetch_s;
    logic       exec1_s;
    logic       exec2_s;

    assign op_s    = IR[15:12];
    assign op_m1_s = op_s - 4'd1;
    assign RD      = IR[11:9];
    assign RA      = IR[8:6];
    assign RB      = IR[5:3];

`ifdef PHASE_CHECK_EN
    logic e2_prev_r;
    logic multi_s;

    assign multi_s = (FETCH & EXEC1) | (FETCH & EXEC2) | (EXEC1 & EXEC2);
    assign err_s   = !RST && !HALTED && (multi_s || (EXEC2 && !e2_prev_r));

    // Remember whether the previous cycle was an EXEC1 that requested EXEC2
    always_ff @(posedge CLK) begin
        if (RST) begin
            e2_prev_r <= 1'b0;
            PHASE_ERR <= 1'b0;
        end else begin
            e2_prev_r <= E2;
            PHASE_ERR <= PHASE_ERR | err_s;
        end
    end
`else
    assign err_s = 1'b0;
`endif

    // A faulty phase cycle is ignored entirely, strobes and state alike
    assign live_s  = !RST && !HALTED && !err_s;
    assign fetch_s = live_s && FETCH;
    assign exec1_s = live_s && EXEC1;
    assign exec2_s = live_s && EXEC2;

    // Per-phase decode of the held instruction into datapath strobes
    always_comb begin
        E2       = 1'b0;
        ADDR_SEL = 1'b0;
        REG_WE   = 1'b0;
        WB_SEL   = 1'b0;
        MEM_WE   = 1'b0;
        ALU_OP   = 2'b00;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                if (exec1_s) begin
                    REG_WE = 1'b1;
                    ALU_OP = op_m1_s[1:0];
                end else begin
                    REG_WE = 1'b0;
                end
            end
            OP_LDI: begin
                if (exec1_s) begin
                    E2 = 1'b1;
                end else if (exec2_s) begin
                    REG_WE = 1'b1;
                    WB_SEL = 1'b1;
                end else begin
                    E2 = 1'b0;
                end
            end
            OP_LD: begin
                if (exec1_s) begin
                    ADDR_SEL = 1'b1;
                    E2       = 1'b1;
                end else if (exec2_s) begin
                    ADDR_SEL = 1'b1;
                    REG_WE   = 1'b1;
                    WB_SEL   = 1'b1;
                end else begin
                    ADDR_SEL = 1'b0;
                end
            end
            OP_ST: begin
                if (exec1_s) begin
                    ADDR_SEL = 1'b1;
                    MEM_WE   = 1'b1;
                end else begin
                    MEM_WE = 1'b0;
                end
            end
            default: begin
                E2 = 1'b0;
            end
        endcase
    end

    // PC, IR and sticky status; HALTED freezes everything until reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC      <= RESET_VEC;
            IR      <= 16'h0000;
            HALTED  <= 1'b0;
            ILLEGAL <= 1'b0;
        end else if (fetch_s) begin
            IR <= MEM_DATA;
            PC <= PC + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (exec1_s) begin
            case (op_s)
                OP_JMP:                PC      <= IR[ADDR_W-1:0];
                OP_JZ:  if (FLAG_Z)    PC      <= IR[ADDR_W-1:0];
                OP_JC:  if (FLAG_C)    PC      <= IR[ADDR_W-1:0];
                OP_HLT:                HALTED  <= 1'b1;
                4'hB, 4'hC, 4'hD, 4'hE: ILLEGAL <= 1'b1;
                default:               PC      <= PC;
            endcase
        end else if (exec2_s && op_s == OP_LDI) begin
            // LDI consumed the operand word at PC, so step past it
            PC <= PC + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            PC <= PC;
        end
    end

endmodule
